// File: rtl/micro_scan_pkg.sv
// Shared types, constants and helpers for the micro-tile scan controller.
// Build option: MICRO_SCAN_LFSR_EN selects an 8-bit Galois LFSR stimulus
// instead of the default incrementing counter.
package micro_scan_pkg;

    localparam int unsigned     SIG_W     = 16;
    localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
    localparam logic [7:0]       LFSR_TAPS = 8'hB8;

`ifdef MICRO_SCAN_LFSR_EN
    localparam logic [7:0] STIM_SEED = 8'h01;
`else
    localparam logic [7:0] STIM_SEED = 8'h00;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StTreset,
        StRun,
        StReport,
        StDone
    } scan_state_e;

    // One signature fold: CRC-style shift with the tile output byte XORed into the low bits.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [7:0]       din);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0)
               ^ {{(SIG_W-8){1'b0}}, din};
    endfunction

    // Next stimulus byte driven to the tile.
    function automatic logic [7:0] stim_next(input logic [7:0] s);
`ifdef MICRO_SCAN_LFSR_EN
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
`else
        return s + 8'd1;
`endif
    endfunction

endpackage

// File: rtl/micro_scan_sig.sv
// 16-bit per-tile signature register: load seed, or fold one byte per enabled cycle.
module micro_scan_sig
    import micro_scan_pkg::*;
#(
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [7:0]       din,
    output logic [SIG_W-1:0] sig
);

    // Load takes priority so each tile starts from a clean seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_step(sig, din);
        end
    end

endmodule

// File: rtl/micro_tile_scan_ctrl.sv
// Host-side scan initiator for the micro-tile container select mux.
// Walks the enabled tiles in ascending order: select, reset, stimulate/capture, report.
// Build option: MICRO_SCAN_LFSR_EN (LFSR stimulus instead of counter, see micro_scan_pkg).
module micro_tile_scan_ctrl
    import micro_scan_pkg::*;
#(
    parameter int unsigned    NUM_TILES     = 4,
    parameter int unsigned    SETTLE_CYCLES = 2,
    parameter int unsigned    RST_CYCLES    = 4,
    parameter int unsigned    RUN_CYCLES    = 16,
    parameter logic [15:0]    SIG_SEED      = 16'hFFFF,
    localparam int unsigned   SEL_W         = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       tile_mask,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] sel_out,
    output logic             tile_rst_n,
    output logic [7:0]       tile_ui,
    input  logic [7:0]       tile_uo,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SEL_W-1:0] res_tile,
    output logic [15:0]      res_sig
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);

    scan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    logic [SEL_W:0]   first_tile;
    logic [SEL_W:0]   next_tile;

    // Lowest enabled tile at or above 'from'; MSB of the result flags a hit.
    // Mask bits at or above NUM_TILES never match.
    function automatic logic [SEL_W:0] find_tile(input logic [3:0] m, input int from);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i < int'(NUM_TILES) && i >= from && m[i]) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    // Tile search for scan start and for the step after each report.
    always_comb begin
        first_tile = find_tile(tile_mask, 0);
        next_tile  = find_tile(mask_q, int'(sel_out) + 1);
    end

    // Scan FSM with registered outputs; sel_out only moves on SELECT entry while tile_rst_n=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            mask_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sel_out    <= '0;
            tile_rst_n <= 1'b0;
            tile_ui    <= 8'h00;
            res_valid  <= 1'b0;
            res_tile   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // 'done' high means the previous scan just ended; a start there is dropped.
                    if (start && !done) begin
                        mask_q <= tile_mask;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        if (first_tile[SEL_W]) begin
                            sel_out <= first_tile[SEL_W-1:0];
                            state   <= StSelect;
                        end else begin
                            state <= StDone;
                        end
                    end
                end
                StSelect: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= StTreset;
                    end
                end
                StTreset: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RST_LAST) begin
                        cnt        <= '0;
                        tile_rst_n <= 1'b1;
                        tile_ui    <= STIM_SEED;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    cnt     <= cnt + 1'b1;
                    tile_ui <= stim_next(tile_ui);
                    if (cnt == RUN_LAST) begin
                        cnt        <= '0;
                        tile_rst_n <= 1'b0;
                        tile_ui    <= 8'h00;
                        res_valid  <= 1'b1;
                        res_tile   <= sel_out;
                        state      <= StReport;
                    end
                end
                StReport: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (next_tile[SEL_W]) begin
                            sel_out <= next_tile[SEL_W-1:0];
                            state   <= StSelect;
                        end else begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    micro_scan_sig #(
        .SEED (SIG_SEED)
    ) u_sig (
        .clk  (clk),
        .rst  (rst),
        .load (state == StTreset),
        .en   (state == StRun),
        .din  (tile_uo),
        .sig  (res_sig)
    );

endmodule

// File: tb/tb_micro_tile_scan_ctrl.sv
// Self-checking bench for micro_tile_scan_ctrl: a default-parameter DUT with a result
// scoreboard, plus a short-run DUT (RUN_CYCLES=1, NUM_TILES=3) for fixed signatures.
module tb_micro_tile_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT
    logic       start, busy, done, tile_rst_n, res_valid, res_ready;
    logic [3:0] tile_mask;
    logic [1:0] sel_out, res_tile;
    logic [7:0] tile_ui, tile_uo, uo_const;
    logic [15:0] res_sig;
    logic       echo;
    assign tile_uo = echo ? tile_ui : uo_const;

    // Short DUT
    logic       s_start, s_busy, s_done, s_tile_rst_n, s_res_valid, s_res_ready;
    logic [3:0] s_mask;
    logic [1:0] s_sel_out, s_res_tile;
    logic [7:0] s_tile_ui, s_uo;
    logic [15:0] s_res_sig;

    micro_tile_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .tile_mask(tile_mask), .busy(busy), .done(done),
        .sel_out(sel_out), .tile_rst_n(tile_rst_n), .tile_ui(tile_ui), .tile_uo(tile_uo),
        .res_valid(res_valid), .res_ready(res_ready), .res_tile(res_tile), .res_sig(res_sig)
    );

    micro_tile_scan_ctrl #(.NUM_TILES(3), .RUN_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .tile_mask(s_mask), .busy(s_busy),
        .done(s_done), .sel_out(s_sel_out), .tile_rst_n(s_tile_rst_n), .tile_ui(s_tile_ui),
        .tile_uo(s_uo), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_tile(s_res_tile), .res_sig(s_res_sig)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  tile;
        logic [15:0] sig;
    } res_t;
    res_t exp_q[$];
    res_t e_mon;
    int   n_results = 0;

`ifdef MICRO_SCAN_LFSR_EN
    localparam logic [7:0] STIM0 = 8'h01;
    function automatic logic [7:0] nstim(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction
`else
    localparam logic [7:0] STIM0 = 8'h00;
    function automatic logic [7:0] nstim(input logic [7:0] s);
        return s + 8'd1;
    endfunction
`endif

    function automatic logic [7:0] stim_at(input int k);
        logic [7:0] s;
        s = STIM0;
        for (int i = 0; i < k; i++) s = nstim(s);
        return s;
    endfunction

    function automatic logic [15:0] model_sig(input int run, input bit echo_m,
                                              input logic [7:0] c);
        logic [15:0] s;
        logic [7:0]  st, uo;
        s  = 16'hFFFF;
        st = STIM0;
        for (int k = 0; k < run; k++) begin
            uo = echo_m ? st : c;
            s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, uo};
            st = nstim(st);
        end
        return s;
    endfunction

    task automatic push_scan(input logic [3:0] m, input bit echo_m, input logic [7:0] c);
        res_t e;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.tile = 2'(i);
                e.sig  = model_sig(16, echo_m, c);
                exp_q.push_back(e);
            end
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted result of the main DUT is popped and compared.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            checks++;
            n_results++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got tile=%0d sig=%h, required no result",
                         res_tile, res_sig);
            end else begin
                e_mon = exp_q.pop_front();
                if (res_tile !== e_mon.tile || res_sig !== e_mon.sig) begin
                    errors++;
                    $display("FAIL sb_result: got tile=%0d sig=%h, required tile=%0d sig=%h",
                             res_tile, res_sig, e_mon.tile, e_mon.sig);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({busy, done, sel_out, tile_rst_n, tile_ui, res_valid, res_tile, res_sig} !== '0) begin
            errors++;
            $display("FAIL reset_main: got %h, required 0",
                     {busy, done, sel_out, tile_rst_n, tile_ui, res_valid, res_tile, res_sig});
        end
        checks++;
        if ({s_busy, s_done, s_sel_out, s_tile_rst_n, s_tile_ui, s_res_valid, s_res_tile,
             s_res_sig} !== '0) begin
            errors++;
            $display("FAIL reset_short: got busy=%b sel=%0d sig=%h, required all 0",
                     s_busy, s_sel_out, s_res_sig);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Runs one short-DUT scan with a single expected result and checks tile, sig, sel, done.
    task automatic test_run1(input string name, input logic [3:0] m, input logic [7:0] uo,
                             input logic [1:0] etile, input logic [15:0] esig);
        bit got, sel_bad, dn;
        got = 0; sel_bad = 0; dn = 0;
        s_uo = uo; s_mask = m; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (s_busy && s_sel_out !== etile) sel_bad = 1;
            if (s_res_valid) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_valid: got no res_valid, required one", name);
        end
        checks++;
        if (s_res_tile !== etile || s_res_sig !== esig) begin
            errors++;
            $display("FAIL %s_result: got tile=%0d sig=%h, required tile=%0d sig=%h",
                     name, s_res_tile, s_res_sig, etile, esig);
        end
        checks++;
        if (sel_bad) begin
            errors++;
            $display("FAIL %s_sel: got sel_out other than %0d while busy, required %0d",
                     name, etile, etile);
        end
        tick();
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        for (int c = 0; c < 10 && !dn; c++) begin
            @(negedge clk);
            if (s_done) dn = 1;
        end
        checks++;
        if (!dn) begin
            errors++;
            $display("FAIL %s_done: got no done pulse, required one", name);
        end
        tick();
    endtask

    // Short DUT has 3 tiles, so mask bit 3 must be ignored: immediate done, no result.
    task automatic test_mask_ignore();
        bit seen_valid, dn;
        seen_valid = 0; dn = 0;
        s_mask = 4'b1000; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_res_valid) seen_valid = 1;
            if (s_done) dn = 1;
        end
        checks++;
        if (seen_valid || !dn) begin
            errors++;
            $display("FAIL mask_ignore: got valid=%b done=%b, required valid=0 done=1",
                     seen_valid, dn);
        end
        tick();
    endtask

    task automatic test_echo_scan();
        bit dn, sel_bad, ui_bad;
        int k, run_total;
        logic [1:0] prev_sel;
        dn = 0; sel_bad = 0; ui_bad = 0; k = 0; run_total = 0;
        echo = 1'b1; res_ready = 1'b1;
        prev_sel = sel_out;
        push_scan(4'b1011, 1'b1, 8'h00);
        tile_mask = 4'b1011; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && !dn; c++) begin
            @(negedge clk);
            if (sel_out !== prev_sel && tile_rst_n !== 1'b0) sel_bad = 1;
            prev_sel = sel_out;
            if (tile_rst_n === 1'b1) begin
                if (tile_ui !== stim_at(k)) ui_bad = 1;
                k++;
                run_total++;
            end else begin
                k = 0;
            end
            if (done) dn = 1;
        end
        checks++;
        if (!dn) begin
            errors++;
            $display("FAIL echo_done: got no done within bound, required done");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL echo_results: got %0d results pending, required 0", exp_q.size());
        end
        checks++;
        if (ui_bad || run_total != 48) begin
            errors++;
            $display("FAIL echo_stim: got ui_bad=%b run_cycles=%0d, required 0 and 48",
                     ui_bad, run_total);
        end
        checks++;
        if (sel_bad) begin
            errors++;
            $display("FAIL echo_sel: got sel_out change with tile_rst_n=1, required none");
        end
        echo = 1'b0;
        tick();
    endtask

    task automatic test_empty_mask();
        tile_mask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_busy: got busy=%b done=%b valid=%b, required 1 0 0",
                     busy, done, res_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got busy=%b done=%b valid=%b, required 0 1 0",
                     busy, done, res_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse: got done=%b, required 0", done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit got, unstable, dn, restart;
        logic [1:0]  t0, s0;
        logic [15:0] g0;
        got = 0; unstable = 0; dn = 0; restart = 0;
        res_ready = 1'b0; uo_const = 8'h3C;
        push_scan(4'b0010, 1'b0, 8'h3C);
        tile_mask = 4'b0010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_valid: got no res_valid, required one");
        end
        t0 = res_tile; g0 = res_sig; s0 = sel_out;
        for (int c = 0; c < 20; c++) begin
            tick();
            start = (c % 3 == 0);
            tile_mask = 4'b0001;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_tile !== t0 || res_sig !== g0 || sel_out !== s0
                || busy !== 1'b1) unstable = 1;
        end
        checks++;
        if (unstable || t0 !== 2'd1) begin
            errors++;
            $display("FAIL bp_stable: got unstable=%b tile=%0d, required 0 and tile 1",
                     unstable, t0);
        end
        tick();
        start = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 10 && !dn; c++) begin
            @(negedge clk);
            if (done) dn = 1;
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy) restart = 1;
        end
        checks++;
        if (!dn || restart || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drop: got done=%b restart=%b pending=%0d, required 1 0 0",
                     dn, restart, exp_q.size());
        end
        tick();
    endtask

    // start held through REPORT, the final DONE step and the done pulse must not restart.
    task automatic test_start_at_done();
        bit got, dn, restart;
        got = 0; dn = 0; restart = 0;
        res_ready = 1'b0;
        push_scan(4'b0001, 1'b0, 8'h3C);
        tile_mask = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (res_valid) got = 1;
        end
        start = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 10 && !dn; c++) begin
            tick();
            if (done) dn = 1;
        end
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy) restart = 1;
        end
        checks++;
        if (!got || !dn || restart) begin
            errors++;
            $display("FAIL start_at_done: got valid=%b done=%b restart=%b, required 1 1 0",
                     got, dn, restart);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit in_run, dn, spurious;
        in_run = 0; dn = 0; spurious = 0;
        echo = 1'b1; res_ready = 1'b1;
        tile_mask = 4'b0110; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60 && !in_run; c++) begin
            @(negedge clk);
            if (tile_rst_n) in_run = 1;
        end
        checks++;
        if (!in_run) begin
            errors++;
            $display("FAIL mid_reach_run: got no RUN phase, required tile_rst_n=1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sel_out, tile_rst_n, tile_ui, res_valid, res_tile, res_sig} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %h, required 0",
                     {busy, done, sel_out, tile_rst_n, tile_ui, res_valid, res_tile, res_sig});
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_valid || busy) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL mid_idle: got activity after reset, required idle");
        end
        push_scan(4'b0110, 1'b1, 8'h00);
        tick();
        tile_mask = 4'b0110; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (sel_out !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_rescan: got sel=%0d busy=%b, required sel=1 busy=1",
                     sel_out, busy);
        end
        for (int c = 0; c < 200 && !dn; c++) begin
            @(negedge clk);
            if (done) dn = 1;
        end
        checks++;
        if (!dn || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_rescan_done: got done=%b pending=%0d, required 1 0",
                     dn, exp_q.size());
        end
        echo = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; tile_mask = '0; res_ready = 1'b0; echo = 1'b0; uo_const = 8'h00;
        s_start = 1'b0; s_mask = '0; s_res_ready = 1'b0; s_uo = 8'h00;
        test_reset();
        test_run1("run1_zero", 4'b0001, 8'h00, 2'd0, 16'hEFDF);
        test_run1("run1_5a", 4'b0100, 8'h5A, 2'd2, 16'hEF85);
        test_mask_ignore();
        test_echo_scan();
        test_empty_mask();
        test_backpressure();
        test_start_at_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
